wide_add_seq: RTL



---
 rtl/wide_add_pkg.sv | 12 +
 rtl/wide_add_seq_adder.sv | 22 ++
 rtl/wide_add_seq.sv | 128 ++++++++++++
 3 files changed

// File: rtl/wide_add_pkg.sv
// Shared types and constants for the byte-serial wide adder.
package wide_add_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

endpackage

// File: rtl/wide_add_seq_adder.sv
// 8-bit ripple-carry adder shared by the wide-add sequencer.
module adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    // Ripple the carry through each bit position.
    always_comb begin
        logic carry;
        carry = cin;
        sum   = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/wide_add_seq.sv
// Multi-precision adder: sums two NBYTES-byte operands one byte per clock
// through a single 8-bit adder, with valid/ready handshakes on both sides.
module wide_add_seq
    import wide_add_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BYTE_W*NBYTES-1:0] in_a,
    input  logic [BYTE_W*NBYTES-1:0] in_b,
    input  logic                     in_cin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BYTE_W*NBYTES-1:0] out_sum,
    output logic                     out_cout
);

    localparam int W     = BYTE_W * NBYTES;
    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_t            state;
    state_t            state_next;
    logic [W-1:0]      a_reg;
    logic [W-1:0]      b_reg;
    logic              carry;
    logic [IDX_W-1:0]  idx;
    logic [BYTE_W-1:0] a_byte;
    logic [BYTE_W-1:0] b_byte;
    logic [BYTE_W-1:0] sum_byte;
    logic              cout_byte;
    logic              last_byte;

    assign last_byte = (idx == LAST_IDX);

    // Select the operand byte currently being added.
    always_comb begin
        a_byte = a_reg[idx*BYTE_W +: BYTE_W];
        b_byte = b_reg[idx*BYTE_W +: BYTE_W];
    end

    adder u_adder (
        .a    (a_byte),
        .b    (b_byte),
        .cin  (carry),
        .sum  (sum_byte),
        .cout (cout_byte)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and input-side handshake.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        unique case (state)
            S_IDLE: begin
                in_ready = !rst;
                if (in_valid) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (last_byte) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Operand capture, byte-serial accumulation and result hand-off.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_reg <= in_a;
                        b_reg <= in_b;
                        carry <= in_cin;
                        idx   <= '0;
                    end
                end
                S_RUN: begin
                    out_sum[idx*BYTE_W +: BYTE_W] <= sum_byte;
                    carry                         <= cout_byte;
                    if (last_byte) begin
                        // idx parks at the top byte so it never exceeds NBYTES-1.
                        out_cout  <= cout_byte;
                        out_valid <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
